// File: rtl/midi_pkg.sv
// -----------------------------------------------------------------------------
// midi_pkg
// Shared definitions for the MIDI note tracker: MIDI status nibbles, the
// internal "no note" target code and the message FSM state encoding.
// Related build option: MIDI_RUNNING_STATUS_EN (used by midi_note_tracker).
// -----------------------------------------------------------------------------
package midi_pkg;

  localparam logic [7:0] NOTE_OFF = 8'h80;
  localparam logic [7:0] NOTE_ON  = 8'h90;

  // Target code meaning "no note should sound". Real notes are 0..127,
  // so bit 7 set can never collide with a note number.
  localparam logic [7:0] SILENT   = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECIDE,
    ST_OFF_S,
    ST_OFF_N,
    ST_OFF_V,
    ST_ON_S,
    ST_ON_N,
    ST_ON_V
  } state_t;

endpackage

// File: rtl/midi_note_map.sv
// -----------------------------------------------------------------------------
// midi_note_map
// Combinational distance -> note mapping.
//   in  i_dist   [DIST_W]  distance in cm
//   out o_target [8]       note number 0..127, or SILENT when out of range
// note = BASE_NOTE + ((d - MIN_CM) >> CM_SHIFT), saturated at 127,
// for MIN_CM <= d <= MAX_CM. Arithmetic is one bit wider than the input so
// the base-note addition cannot wrap.
// -----------------------------------------------------------------------------
module midi_note_map
  import midi_pkg::*;
#(
  parameter int DIST_W    = 16,
  parameter int MIN_CM    = 2,
  parameter int MAX_CM    = 60,
  parameter int CM_SHIFT  = 1,
  parameter int BASE_NOTE = 48
) (
  input  logic [DIST_W-1:0] i_dist,
  output logic [7:0]        o_target
);

  localparam int AW = DIST_W + 1;

  logic [AW-1:0] w_d;
  logic [AW-1:0] w_off;
  logic [AW-1:0] w_note;

  assign w_d = {1'b0, i_dist};

  always_comb begin
    o_target = SILENT;
    w_off    = w_d - AW'(MIN_CM);
    w_note   = AW'(BASE_NOTE) + (w_off >> CM_SHIFT);
    if ((w_d >= AW'(MIN_CM)) && (w_d <= AW'(MAX_CM))) begin
      o_target = (w_note > AW'(127)) ? 8'd127 : {1'b0, w_note[6:0]};
    end
  end

endmodule

// File: rtl/midi_note_tracker.sv
// -----------------------------------------------------------------------------
// midi_note_tracker
// Turns a stream of distance samples into MIDI Note Off / Note On messages
// for a byte-wide UART transmitter. Nothing is sent when the note does not
// change; the note is silenced when the hand leaves range or (optionally)
// when samples stop arriving for TIMEOUT_CYC cycles.
//
// Ports
//   clk             in   system clock
//   rst             in   asynchronous, active-low reset
//   distance_cm     in   distance sample, valid with distance_ready
//   distance_ready  in   1-cycle strobe: new sample present
//   midi_byte       out  byte offered to the UART
//   midi_send       out  valid for midi_byte (held until uart_ready)
//   uart_ready      in   UART accepts midi_byte this cycle
//   note_active     out  a note is currently sounding
//   current_note    out  sounding note number (0 when inactive)
//
// Build option MIDI_RUNNING_STATUS_EN: Note Off is sent as Note On with
// velocity 0 and a status byte equal to the last accepted one is dropped.
// -----------------------------------------------------------------------------
module midi_note_tracker
  import midi_pkg::*;
#(
  parameter int DIST_W      = 16,
  parameter int MIN_CM      = 2,
  parameter int MAX_CM      = 60,
  parameter int CM_SHIFT    = 1,
  parameter int BASE_NOTE   = 48,
  parameter int CHANNEL     = 0,
  parameter int VELOCITY    = 100,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIST_W-1:0] distance_cm,
  input  logic              distance_ready,
  output logic [7:0]        midi_byte,
  output logic              midi_send,
  input  logic              uart_ready,
  output logic              note_active,
  output logic [6:0]        current_note
);

`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit         RS_EN  = 1'b1;
  localparam logic [7:0] OFF_ST = NOTE_ON  | 8'(CHANNEL & 15);
`else
  localparam bit         RS_EN  = 1'b0;
  localparam logic [7:0] OFF_ST = NOTE_OFF | 8'(CHANNEL & 15);
`endif
  localparam logic [7:0] ON_ST  = NOTE_ON  | 8'(CHANNEL & 15);
  localparam logic [7:0] VEL    = 8'(VELOCITY & 127);

  state_t      r_state;
  state_t      w_nxt;
  logic [7:0]  r_byte;
  logic        r_send;
  logic        r_active;
  logic [6:0]  r_note;
  logic [7:0]  r_target;
  logic        r_pend_vld;
  logic [7:0]  r_pend;
  logic [7:0]  w_map;
  logic [7:0]  w_cur_code;
  logic [7:0]  w_last;
  logic        w_acc;
  logic        w_to_fire;

  assign midi_byte    = r_byte;
  assign midi_send    = r_send;
  assign note_active  = r_active;
  assign current_note = r_note;

  midi_note_map #(
    .DIST_W    (DIST_W),
    .MIN_CM    (MIN_CM),
    .MAX_CM    (MAX_CM),
    .CM_SHIFT  (CM_SHIFT),
    .BASE_NOTE (BASE_NOTE)
  ) u_map (
    .i_dist   (distance_cm),
    .o_target (w_map)
  );

  // A status state is skipped when running status makes it redundant.
  function automatic state_t enter_st(state_t s, logic [7:0] last);
    if (RS_EN && (s == ST_OFF_S) && (last == OFF_ST)) return ST_OFF_N;
    if (RS_EN && (s == ST_ON_S)  && (last == ON_ST))  return ST_ON_N;
    return s;
  endfunction

  function automatic logic [7:0] byte_for(state_t s, logic [6:0] cur, logic [6:0] tgt);
    case (s)
      ST_OFF_S: return OFF_ST;
      ST_OFF_N: return {1'b0, cur};
      ST_OFF_V: return 8'h00;
      ST_ON_S:  return ON_ST;
      ST_ON_N:  return {1'b0, tgt};
      ST_ON_V:  return VEL;
      default:  return 8'h00;
    endcase
  endfunction

  function automatic logic is_tx(state_t s);
    return (s != ST_IDLE) && (s != ST_DECIDE);
  endfunction

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] r_last;
  assign w_last = r_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= 8'h00;
    end else if (w_acc && ((r_state == ST_OFF_S) || (r_state == ST_ON_S))) begin
      r_last <= r_byte;
    end
  end
`else
  assign w_last = 8'h00;
`endif

  // Inactivity timeout: injects a SILENT request only from IDLE with nothing
  // pending, so it never interrupts a message or competes with a sample.
  generate
    if (TIMEOUT_CYC > 0) begin : g_timeout
      localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
      localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);
      logic [TO_W-1:0] r_to_cnt;

      assign w_to_fire = (r_to_cnt == TO_MAX) && r_active && !r_pend_vld &&
                         (r_state == ST_IDLE);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_to_cnt <= '0;
        end else if (distance_ready || w_to_fire) begin
          r_to_cnt <= '0;
        end else if (r_to_cnt != TO_MAX) begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
    end else begin : g_no_timeout
      assign w_to_fire = 1'b0;
    end
  endgenerate

  // Pending request: a fresh sample always overwrites, then a timeout
  // injection, otherwise it is consumed when IDLE picks it up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_vld <= 1'b0;
      r_pend     <= SILENT;
    end else if (distance_ready) begin
      r_pend_vld <= 1'b1;
      r_pend     <= w_map;
    end else if (w_to_fire) begin
      r_pend_vld <= 1'b1;
      r_pend     <= SILENT;
    end else if ((r_state == ST_IDLE) && r_pend_vld) begin
      r_pend_vld <= 1'b0;
    end
  end

  assign w_cur_code = r_active ? {1'b0, r_note} : SILENT;
  assign w_acc      = r_send && uart_ready;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (r_pend_vld) w_nxt = ST_DECIDE;
      ST_DECIDE: begin
        if (r_target == w_cur_code) w_nxt = ST_IDLE;
        else if (r_active)          w_nxt = enter_st(ST_OFF_S, w_last);
        else                        w_nxt = enter_st(ST_ON_S, w_last);
      end
      ST_OFF_S:  if (w_acc) w_nxt = ST_OFF_N;
      ST_OFF_N:  if (w_acc) w_nxt = ST_OFF_V;
      ST_OFF_V:  if (w_acc) w_nxt = (r_target == SILENT) ? ST_IDLE : enter_st(ST_ON_S, w_last);
      ST_ON_S:   if (w_acc) w_nxt = ST_ON_N;
      ST_ON_N:   if (w_acc) w_nxt = ST_ON_V;
      ST_ON_V:   if (w_acc) w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  // Byte and valid are registered together with the state, so the next
  // byte appears in the cycle after the previous one was accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_send   <= 1'b0;
      r_byte   <= 8'h00;
      r_active <= 1'b0;
      r_note   <= 7'd0;
      r_target <= SILENT;
    end else begin
      r_state <= w_nxt;
      if ((r_state == ST_IDLE) && r_pend_vld) r_target <= r_pend;
      if (is_tx(w_nxt)) begin
        r_send <= 1'b1;
        r_byte <= byte_for(w_nxt, r_note, r_target[6:0]);
      end else begin
        r_send <= 1'b0;
      end
      if (w_acc && (r_state == ST_OFF_V)) begin
        r_active <= 1'b0;
        r_note   <= 7'd0;
      end
      if (w_acc && (r_state == ST_ON_V)) begin
        r_active <= 1'b1;
        r_note   <= r_target[6:0];
      end
    end
  end

endmodule

// File: tb/tb_midi_note_tracker.sv
// -----------------------------------------------------------------------------
// tb_midi_note_tracker
// Bench for midi_note_tracker. Instance u_dut uses default parameters;
// u_to uses TIMEOUT_CYC=50. Expected MIDI bytes are queued when a sample is
// strobed and popped as the DUT hands bytes to the UART side.
// Honors MIDI_RUNNING_STATUS_EN for the expected byte stream.
// -----------------------------------------------------------------------------
module tb_midi_note_tracker;

`ifdef MIDI_RUNNING_STATUS_EN
  localparam logic [7:0] OFF_ST = 8'h90;
  localparam logic [7:0] HOLD_B = 8'h64;
`else
  localparam logic [7:0] OFF_ST = 8'h80;
  localparam logic [7:0] HOLD_B = 8'h4A;
`endif
  localparam logic [7:0] ON_ST = 8'h90;
  localparam logic [7:0] VEL   = 8'h64;

  logic        clk;
  logic        rst1, rst2;
  logic [15:0] d1, d2;
  logic        dr1, dr2;
  logic [7:0]  byte1, byte2;
  logic        send1, send2;
  logic        ready1, ready2;
  logic        act1, act2;
  logic [6:0]  note1, note2;

  int n_cmp = 0;
  int n_bad = 0;
  int acc1  = 0;
  bit ready_en = 1'b0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] ls[2];
`endif

  typedef struct {
    int d;
    bit act;
    int note;
  } vec_t;
  vec_t tbl[15];

  midi_note_tracker u_dut (
    .clk            (clk),
    .rst            (rst1),
    .distance_cm    (d1),
    .distance_ready (dr1),
    .midi_byte      (byte1),
    .midi_send      (send1),
    .uart_ready     (ready1),
    .note_active    (act1),
    .current_note   (note1)
  );

  midi_note_tracker #(.TIMEOUT_CYC(50)) u_to (
    .clk            (clk),
    .rst            (rst2),
    .distance_cm    (d2),
    .distance_ready (dr2),
    .midi_byte      (byte2),
    .midi_send      (send2),
    .uart_ready     (ready2),
    .note_active    (act2),
    .current_note   (note2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input int w, input logic [7:0] b);
    if (w == 0) q1.push_back(b);
    else        q2.push_back(b);
  endtask

  task automatic push_status(input int w, input logic [7:0] s);
`ifdef MIDI_RUNNING_STATUS_EN
    if (ls[w] == s) return;
    ls[w] = s;
`endif
    push_byte(w, s);
  endtask

  // Reference message model: previous (active,note) -> new (active,note).
  task automatic push_msgs(input int w, input bit pa, input int pn, input bit na, input int nn);
    if ((pa == na) && (!pa || (pn == nn))) return;
    if (pa) begin
      push_status(w, OFF_ST);
      push_byte(w, 8'(pn));
      push_byte(w, 8'h00);
    end
    if (na) begin
      push_status(w, ON_ST);
      push_byte(w, 8'(nn));
      push_byte(w, VEL);
    end
  endtask

  task automatic strobe(input int w, input int d);
    @(posedge clk); #1;
    if (w == 0) begin d1 = 16'(d); dr1 = 1'b1; end
    else        begin d2 = 16'(d); dr2 = 1'b1; end
    @(posedge clk); #1;
    dr1 = 1'b0;
    dr2 = 1'b0;
  endtask

  task automatic drain(input int w, input string name);
    for (int i = 0; i < 300; i++) begin
      if (((w == 0) ? q1.size() : q2.size()) == 0) break;
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk({name, "_drain"}, (w == 0) ? q1.size() : q2.size(), 0);
  endtask

  // UART model for u_dut: one-cycle ready pulse per offered byte.
  initial begin
    ready1 = 1'b0;
    forever begin
      @(posedge clk); #1;
      ready1 = ready_en && send1 && !ready1;
    end
  end

  // Scoreboard pops: a byte transfers on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (send1 && ready1) begin
        acc1++;
        if (q1.size() == 0) chk("unexpected_byte1", int'(byte1), -1);
        else                chk("byte1", int'(byte1), int'(q1.pop_front()));
      end
      if (send2 && ready2) begin
        if (q2.size() == 0) chk("unexpected_byte2", int'(byte2), -1);
        else                chk("byte2", int'(byte2), int'(q2.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pa;
    int pn;
    int s;
    int bad_hold;
    int n;
    bit seen;

    tbl[0]  = '{20,    1'b1, 57};
    tbl[1]  = '{55,    1'b1, 74};
    tbl[2]  = '{55,    1'b1, 74};
    tbl[3]  = '{70,    1'b0, 0};
    tbl[4]  = '{1,     1'b0, 0};
    tbl[5]  = '{2,     1'b1, 48};
    tbl[6]  = '{3,     1'b1, 48};
    tbl[7]  = '{60,    1'b1, 77};
    tbl[8]  = '{61,    1'b0, 0};
    tbl[9]  = '{0,     1'b0, 0};
    tbl[10] = '{65535, 1'b0, 0};
    tbl[11] = '{20,    1'b1, 57};
    tbl[12] = '{65535, 1'b0, 0};
    tbl[13] = '{59,    1'b1, 76};
    tbl[14] = '{61,    1'b0, 0};

`ifdef MIDI_RUNNING_STATUS_EN
    ls[0] = 8'h00;
    ls[1] = 8'h00;
`endif
    rst1 = 1'b0; rst2 = 1'b0;
    d1 = '0; d2 = '0; dr1 = 1'b0; dr2 = 1'b0; ready2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_send1", int'(send1), 0);
    chk("rst_byte1", int'(byte1), 0);
    chk("rst_act1",  int'(act1),  0);
    chk("rst_note1", int'(note1), 0);
    chk("rst_send2", int'(send2), 0);
    chk("rst_act2",  int'(act2),  0);
    rst1 = 1'b1; rst2 = 1'b1;
    ready_en = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven note sequence.
    pa = 1'b0; pn = 0;
    for (int i = 0; i < 15; i++) begin
      push_msgs(0, pa, pn, tbl[i].act, tbl[i].note);
      strobe(0, tbl[i].d);
      drain(0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_active", i), int'(act1), int'(tbl[i].act));
      chk($sformatf("vec%0d_note", i),   int'(note1), tbl[i].note);
      pa = tbl[i].act; pn = tbl[i].note;
    end

    // UART stalls mid-ON; two samples arrive meanwhile, only the last counts.
    push_msgs(0, 1'b0, 0, 1'b1, 74);
    s = acc1;
    strobe(0, 55);
    for (int i = 0; i < 50 && acc1 == s; i++) @(negedge clk);
    chk("hold_first_accept", acc1, s + 1);
    ready_en = 1'b0;
    repeat (2) @(negedge clk);
    bad_hold = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!(send1 && (byte1 == HOLD_B))) bad_hold++;
    end
    strobe(0, 20);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!(send1 && (byte1 == HOLD_B))) bad_hold++;
    end
    strobe(0, 30);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!(send1 && (byte1 == HOLD_B))) bad_hold++;
    end
    chk("hold_stable", bad_hold, 0);
    push_msgs(0, 1'b1, 74, 1'b1, 62);
    ready_en = 1'b1;
    drain(0, "latest_wins");
    chk("latest_active", int'(act1), 1);
    chk("latest_note",   int'(note1), 62);

    // Timeout instance: note 57 then silence until the auto Note Off.
    ready2 = 1'b1;
    push_msgs(1, 1'b0, 0, 1'b1, 57);
    strobe(1, 20);
    n = 1;
    for (int i = 0; i < 20 && !act2; i++) begin @(negedge clk); n++; end
    chk("to_on_active", int'(act2), 1);
    chk("to_on_note",   int'(note2), 57);
    push_msgs(1, 1'b1, 57, 1'b0, 0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); n++;
      if (send2) begin seen = 1'b1; break; end
    end
    chk("to_fired", int'(seen), 1);
    chk("to_window", int'((n >= 50) && (n <= 58)), 1);
    drain(1, "to_off");
    chk("to_off_active", int'(act2), 0);
    chk("to_off_note",   int'(note2), 0);

    // Asynchronous reset while the ON note byte is being offered.
    ready2 = 1'b0;
    push_msgs(1, 1'b0, 0, 1'b1, 57);
    strobe(1, 20);
    for (int i = 0; i < 20 && !send2; i++) @(negedge clk);
    if (byte2 != 8'h39) begin
      @(posedge clk); #1 ready2 = 1'b1;
      @(posedge clk); #1 ready2 = 1'b0;
    end
    @(negedge clk);
    chk("pre_rst_send", int'(send2), 1);
    chk("pre_rst_byte", int'(byte2), 8'h39);
    #2 rst2 = 1'b0;
    #1;
    chk("rst_on_n_send",   int'(send2), 0);
    chk("rst_on_n_byte",   int'(byte2), 0);
    chk("rst_on_n_active", int'(act2),  0);
    chk("rst_on_n_note",   int'(note2), 0);
    q2.delete();
`ifdef MIDI_RUNNING_STATUS_EN
    ls[1] = 8'h00;
`endif
    @(negedge clk);
    rst2 = 1'b1;
    ready2 = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_active", int'(act2), 0);
    chk("post_rst_send",   int'(send2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
